eth_pkt_sched: RTL and testbench
================================

// Module: eth_pkt_sched
// PURPOSE
//  Scheduler in front of the Ethernet packet former. Watches fill level of two sample FIFOs,
//  round-robin picks a channel holding >= N_BUF words, pulses start to the former, waits for
//  end_tx, then enforces an inter-packet gap. Keeps per-channel packet counters and clears
//  both FIFOs on overflow or on command.
// PARAMETERS
//  N_BUF      360    words per packet; a channel is eligible when afN >= N_BUF
//  DELAY_PKG  125    inter-packet gap in clk cycles after end_tx (0 = no gap)
//  TIMEOUT    4096   max cycles in WAIT_DONE before abort
//  CH_ID0     8'h00  channel id driven for FIFO0;  CH_ID1 8'h01 id for FIFO1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  upr          in   8   [0] en ch0, [1] en ch1, [2] clr request (level), others ignored
//  af0, af1     in   9   FIFO used-words
//  full0, full1 in   1   FIFO full flags
//  end_tx       in   1   former/MAC idle and previous packet done (level, 1 = done)
//  start        out  1   one-cycle start pulse to packet former
//  sel          out  1   FIFO selected for the packet (0/1), held valid START..WAIT_DONE
//  channel      out  8   channel id of selected FIFO (CH_ID0/CH_ID1), same timing as sel
//  nbuf         out  16  packet sequence number of the packet being started
//  fifo_clr     out  1   FIFO clear strobe, 2 cycles
//  busy         out  1   1 in any state except IDLE
//  err_timeout  out  1   sticky; set on watchdog abort, cleared by rst or upr[2]
// BEHAVIOUR
//  Reset: state=IDLE, start=0, sel=0, channel=CH_ID0, nbuf=0, fifo_clr=0, busy=0,
//   err_timeout=0, rr pointer=0 (ch0 has priority first), both pkt counters=0, gap cnt=0.
//  elig0 = upr[0] & (af0 >= N_BUF); elig1 likewise (compare zero-extended to 16 bit).
//  FSM:
//   IDLE : if full0|full1|upr[2] -> CLR. Else if (elig0|elig1) & end_tx -> START.
//          Arbitration: both eligible -> channel != last served; one eligible -> that one.
//          sel/channel latched on the IDLE->START transition.
//   START: start=1 for exactly 1 cycle; nbuf <= cnt[sel]; cnt[sel] <= cnt[sel]+1 (wraps
//          FFFF->0000); rr pointer <= sel. -> WAIT_DONE.
//   WAIT_DONE: ignore end_tx in first cycle (former deasserts it with 1-cycle lag);
//          from 2nd cycle end_tx=1 -> GAP. Watchdog counts; at TIMEOUT -> set
//          err_timeout, -> CLR. full0|full1 here does not interrupt the packet.
//   GAP  : count DELAY_PKG cycles then -> IDLE (DELAY_PKG=0: straight to IDLE next cycle).
//   CLR  : fifo_clr=1 for 2 cycles, cnt0/cnt1 unchanged, then -> IDLE. upr[2] held high
//          re-enters CLR each time IDLE is reached; upr[2] also clears err_timeout.
//  Latency: eligible+end_tx in IDLE at edge k -> start high at cycle k+1.
//  Min packet spacing: start-to-start >= 2 + former time + DELAY_PKG + 1 cycles.
//  Channel disabled (upr bit low) while its packet in flight: packet completes normally.
//  rst mid-packet: immediate return to reset values; no fifo_clr issued.
// STRUCTURE
//  Package eth_pkg: typedef enum logic [2:0] {IDLE,START,WAIT_DONE,GAP,CLR} sched_st_t;
//   UPR_EN0/UPR_EN1/UPR_CLR bit indices; default N_BUF, DELAY_PKG constants.
//  One sub-module natural: eth_rr_arb2 (2-way round-robin, combinational grant + last ptr).
//  Counters (gap, watchdog, cnt0/cnt1) inline.
// TESTING
//  1 rst 10 cyc, upr=3, af0=365, af1=0, end_tx=1 -> start 1 cycle, sel=0, channel=00, nbuf=0.
//  2 af0=af1=365 continuous, former end_tx drops 1 cyc after start, returns after 50 ->
//    sel alternates 0,1,0,1; start-to-start = 2+50+125+1 cycles; nbuf per channel 0,0,1,1.
//  3 af0=359 -> no start; af0=360 -> start next cycle (boundary).
//  4 full1=1 in IDLE -> fifo_clr high exactly 2 cycles, no start; counters preserved.
//  5 end_tx stuck 0 after start, TIMEOUT=64 -> err_timeout=1 at cycle 64, fifo_clr pulse,
//    return to IDLE; upr[2] pulse clears err_timeout.
//  6 rst asserted during GAP and in WAIT_DONE -> all outputs at reset values next cycle;
//    preload cnt0=FFFF -> nbuf=FFFF then 0000 on next ch0 packet.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the Ethernet packet scheduler
// Contents: scheduler state enum, upr bit indices, default timing constants,
// and the channel eligibility helper.
package eth_pkg;

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, GAP, CLR} sched_st_t;

  localparam int UPR_EN0 = 0;
  localparam int UPR_EN1 = 1;
  localparam int UPR_CLR = 2;

  localparam int N_BUF_DEF     = 360;
  localparam int DELAY_PKG_DEF = 125;
  localparam int TIMEOUT_DEF   = 4096;

  // A channel is eligible when enabled and its FIFO holds at least a packet's
  // worth of words; compared at 16 bits so N_BUF above 511 simply never matches.
  function automatic logic chan_eligible(input logic en, input logic [8:0] af,
                                         input int unsigned n_buf);
    return en && ({7'd0, af} >= 16'(n_buf));
  endfunction

endpackage

// File: rtl/eth_rr_arb2.sv
// rtl/eth_rr_arb2.sv - two-way round-robin arbiter for the packet scheduler
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   req[1:0]   per-channel eligibility
//   update     pulse when a grant has been consumed
//   served     channel that was consumed on update
//   grant_sel  combinational pick (0 = ch0, 1 = ch1)
module eth_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant_sel
);

  // prio names the channel that wins a tie; it always points away from the
  // channel served last, and starts at ch0 out of reset.
  logic prio;

  always_comb begin
    grant_sel = 1'b0;
    if (req == 2'b11) grant_sel = prio;
    else              grant_sel = req[1];
  end

  always_ff @(posedge clk) begin
    if (rst)         prio <= 1'b0;
    else if (update) prio <= ~served;
  end

endmodule

// File: rtl/eth_pkt_sched.sv
// rtl/eth_pkt_sched.sv - picks a full FIFO channel, starts the packet former, enforces gap
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   upr[7:0]        [0] enable ch0, [1] enable ch1, [2] clear request (level)
//   af0, af1        FIFO used-words
//   full0, full1    FIFO full flags
//   end_tx          former idle / previous packet done (level)
//   start           one-cycle start pulse to the former
//   sel, channel    selected FIFO and its channel id, valid from START through WAIT_DONE
//   nbuf            per-channel sequence number of the packet being started
//   fifo_clr        two-cycle FIFO clear strobe
//   busy            high whenever not IDLE
//   err_timeout     sticky watchdog abort flag
module eth_pkt_sched
  import eth_pkg::*;
#(
  parameter int          N_BUF     = N_BUF_DEF,
  parameter int          DELAY_PKG = DELAY_PKG_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF,
  parameter logic [7:0]  CH_ID0    = 8'h00,
  parameter logic [7:0]  CH_ID1    = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  upr,
  input  logic [8:0]  af0,
  input  logic [8:0]  af1,
  input  logic        full0,
  input  logic        full1,
  input  logic        end_tx,
  output logic        start,
  output logic        sel,
  output logic [7:0]  channel,
  output logic [15:0] nbuf,
  output logic        fifo_clr,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = (DELAY_PKG == 0) ? 16'd0 : 16'(DELAY_PKG - 1);

  sched_st_t   state, state_nx;
  logic        elig0, elig1, grant;
  logic        load, timeout;
  logic        sel_q;
  logic [15:0] nbuf_q, cnt0, cnt1, wd_cnt, gap_cnt;
  logic        clr_cnt;
  logic        err_q;
  logic        unused_upr;

  assign unused_upr = ^upr[7:3];

  assign elig0 = chan_eligible(upr[UPR_EN0], af0, N_BUF);
  assign elig1 = chan_eligible(upr[UPR_EN1], af1, N_BUF);

  eth_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({elig1, elig0}),
    .update    (state == START),
    .served    (sel_q),
    .grant_sel (grant)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      IDLE: begin
        if (full0 || full1 || upr[UPR_CLR]) begin
          state_nx = CLR;
        end else if ((elig0 || elig1) && end_tx) begin
          state_nx = START;
          load     = 1'b1;
        end
      end
      START: state_nx = WAIT_DONE;
      WAIT_DONE: begin
        // wd_cnt == 0 is the first WAIT_DONE cycle, where end_tx is still the
        // stale "done" from the previous packet.
        if (wd_cnt != 16'd0 && end_tx) begin
          state_nx = GAP;
        end else if (wd_cnt == WD_LAST) begin
          state_nx = CLR;
          timeout  = 1'b1;
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) state_nx = IDLE;
      CLR:     if (clr_cnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      nbuf_q  <= 16'd0;
      cnt0    <= 16'd0;
      cnt1    <= 16'd0;
      wd_cnt  <= 16'd0;
      gap_cnt <= 16'd0;
      clr_cnt <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      // Latch channel and sequence number on the way into START so they are
      // already valid while the start pulse is high.
      if (load) begin
        sel_q  <= grant;
        nbuf_q <= grant ? cnt1 : cnt0;
      end
      if (state == START) begin
        if (sel_q) cnt1 <= cnt1 + 16'd1;
        else       cnt0 <= cnt0 + 16'd1;
      end
      wd_cnt  <= (state == WAIT_DONE) ? wd_cnt + 16'd1 : 16'd0;
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
      clr_cnt <= (state == CLR) ? ~clr_cnt : 1'b0;
      if (timeout)           err_q <= 1'b1;
      else if (upr[UPR_CLR]) err_q <= 1'b0;
    end
  end

  assign start       = (state == START);
  assign busy        = (state != IDLE);
  assign fifo_clr    = (state == CLR);
  assign sel         = sel_q;
  assign channel     = sel_q ? CH_ID1 : CH_ID0;
  assign nbuf        = nbuf_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_eth_pkt_sched.sv
// tb/tb_eth_pkt_sched.sv - scoreboard bench for eth_pkt_sched
module tb_eth_pkt_sched;
  import eth_pkg::*;

  localparam int TMO    = 64;
  localparam int DLY    = 125;
  localparam int FORMER = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  upr;
  logic [8:0]  af0, af1;
  logic        full0, full1, end_tx;
  logic        start, sel, fifo_clr, busy, err_timeout;
  logic [7:0]  channel;
  logic [15:0] nbuf;

  eth_pkt_sched #(
    .N_BUF(360), .DELAY_PKG(DLY), .TIMEOUT(TMO), .CH_ID0(8'h00), .CH_ID1(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .upr(upr), .af0(af0), .af1(af1),
    .full0(full0), .full1(full1), .end_tx(end_tx),
    .start(start), .sel(sel), .channel(channel), .nbuf(nbuf),
    .fifo_clr(fifo_clr), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        sel;
    logic [7:0]  ch;
    logic [15:0] nbuf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_starts = 0;
  logic former_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic s, input logic [7:0] c, input logic [15:0] nb);
    exp_t e;
    e.sel  = s;
    e.ch   = c;
    e.nbuf = nb;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string p);
    check({p, "_start"},    start,       0);
    check({p, "_sel"},      sel,         0);
    check({p, "_channel"},  channel,     8'h00);
    check({p, "_nbuf"},     nbuf,        0);
    check({p, "_fifo_clr"}, fifo_clr,    0);
    check({p, "_busy"},     busy,        0);
    check({p, "_err"},      err_timeout, 0);
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start && n < lim);
    if (!start) check("start_wait_expired", 0, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_end_tx(input int lim);
    int n;
    n = 0;
    while (!end_tx && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("end_tx_returned", end_tx, 1);
  endtask

  // Monitor: every start pulse pops one expected packet descriptor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("start_sel",     sel,     e.sel);
        check("start_channel", channel, e.ch);
        check("start_nbuf",    nbuf,    e.nbuf);
      end
    end
  end

  // Former model: end_tx drops after start and comes back FORMER+1 negedges later.
  always begin
    @(negedge clk);
    if (former_en && start && !rst) begin
      end_tx = 1'b0;
      repeat (FORMER + 1) @(negedge clk);
      end_tx = 1'b1;
    end
  end

  initial begin
    int n, k, clr_hi, start_at;
    int t[4];

    upr = 8'h03; af0 = 9'd365; af1 = 9'd0;
    full0 = 1'b0; full1 = 1'b0; end_tx = 1'b1; rst = 1'b1;
    repeat (10) @(negedge clk);
    check_reset("reset");

    // First packet right out of reset: ch0, nbuf 0, one cycle latency.
    push_exp(1'b0, 8'h00, 16'd0);
    rst = 1'b0;
    wait_start(5, n);
    check("t1_latency", n, 1);
    af0 = 9'd0;
    wait_idle(400);

    // Eligibility boundary at N_BUF.
    af0 = 9'd359;
    k = n_starts;
    repeat (20) @(negedge clk);
    check("t3_no_start_at_359", n_starts, k);
    af0 = 9'd360;
    push_exp(1'b0, 8'h00, 16'd1);
    wait_start(5, n);
    check("t3_latency_at_360", n, 1);
    af0 = 9'd0;
    wait_idle(400);

    // full1 in IDLE wins over an eligible channel; counters survive the clear.
    push_exp(1'b0, 8'h00, 16'd2);
    af0 = 9'd365;
    full1 = 1'b1;
    clr_hi = 0;
    start_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) full1 = 1'b0;
      if (fifo_clr) clr_hi++;
      if (start) begin
        start_at = i;
        af0 = 9'd0;
      end
    end
    check("t4_fifo_clr_cycles", clr_hi, 2);
    check("t4_start_after_clr", start_at, 4);
    wait_idle(400);

    // Both channels loaded continuously: alternate 0,1,0,1 with fixed spacing.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp(1'b0, 8'h00, 16'd0);
    push_exp(1'b1, 8'h01, 16'd0);
    push_exp(1'b0, 8'h00, 16'd1);
    push_exp(1'b1, 8'h01, 16'd1);
    af0 = 9'd365;
    af1 = 9'd365;
    for (int i = 0; i < 4; i++) begin
      wait_start(400, n);
      t[i] = cyc;
    end
    af0 = 9'd0;
    af1 = 9'd0;
    for (int i = 1; i < 4; i++)
      check("t2_start_spacing", t[i] - t[i-1], 2 + FORMER + DLY + 1);
    wait_idle(400);

    // Watchdog: end_tx stuck low after start.
    former_en = 1'b0;
    push_exp(1'b0, 8'h00, 16'd2);
    af0 = 9'd365;
    wait_start(5, n);
    end_tx = 1'b0;
    af0 = 9'd0;
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_cycles", n, TMO + 1);
    check("t5_clr_on_timeout", fifo_clr, 1);
    wait_idle(20);
    check("t5_err_sticky", err_timeout, 1);
    end_tx = 1'b1;
    former_en = 1'b1;
    upr = 8'h07;
    @(negedge clk);
    upr = 8'h03;
    check("t5_err_cleared", err_timeout, 0);
    check("t5_clr_on_upr2", fifo_clr, 1);
    wait_idle(20);

    // Reset during GAP.
    push_exp(1'b0, 8'h00, 16'd3);
    af0 = 9'd365;
    wait_start(5, n);
    af0 = 9'd0;
    @(negedge clk);
    wait_end_tx(100);
    repeat (10) @(negedge clk);
    check("t6_in_gap_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_gap");
    rst = 1'b0;

    // Reset during WAIT_DONE; counters and round-robin pointer start over.
    push_exp(1'b1, 8'h01, 16'd0);
    af1 = 9'd365;
    wait_start(5, n);
    af1 = 9'd0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_wait");
    rst = 1'b0;
    wait_end_tx(100);

    // Sequence counter wrap FFFF -> 0000.
    force dut.cnt0 = 16'hFFFF;
    @(negedge clk);
    release dut.cnt0;
    push_exp(1'b0, 8'h00, 16'hFFFF);
    af0 = 9'd365;
    wait_start(5, n);
    af0 = 9'd0;
    wait_idle(400);
    push_exp(1'b0, 8'h00, 16'h0000);
    af0 = 9'd365;
    wait_start(5, n);
    af0 = 9'd0;
    wait_idle(400);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
